alu_driver: RTL and testbench

ALU_DRIVER -- requirements
Module: alu_driver

---
 rtl/alu_pkg.sv | 33 +++
 rtl/alu_driver_cmd_fifo.sv | 55 +++++
 rtl/alu_driver.sv | 127 ++++++++++++
 tb/tb_alu_driver.sv | 351 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// alu_pkg: shared definitions for the ALU command driver.
//   - ALU opcode encodings driven on 'control'
//   - bit positions of the flags inside rsp_flags ({V,C,N,Z})
//   - driver FSM state type and the packed command format held in the FIFO
package alu_pkg;

    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_SUB = 2'b01;
    localparam logic [1:0] ALU_AND = 2'b10;
    localparam logic [1:0] ALU_OR  = 2'b11;

    localparam int FLAG_V = 3;
    localparam int FLAG_C = 2;
    localparam int FLAG_N = 1;
    localparam int FLAG_Z = 0;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

    // One queued command: opcode plus both operands.
    typedef struct packed {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
    } cmd_t;

    localparam int CMD_W = $bits(cmd_t);

endpackage

// File: rtl/alu_driver_cmd_fifo.sv
// cmd_fifo: synchronous command FIFO for alu_driver.
//   clk, rst      : clock, synchronous active-high reset (empties the FIFO)
//   push, wdata   : write strobe and data; ignored while full
//   full          : no free entry
//   pop, rdata    : read strobe and head entry (rdata valid while !empty)
//   empty         : no stored entry
// Pointers carry one extra bit so full and empty are told apart when the
// index bits match.
module cmd_fifo
    import alu_pkg::*;
#(
    parameter int WIDTH = CMD_W,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    output logic             full,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wptr;
    logic [AW:0]      rptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (wptr == rptr);
    assign full    = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
    assign rdata   = mem[rptr[AW-1:0]];
    // A push into a full FIFO is refused even if a pop happens the same cycle.
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (do_push) wptr <= wptr + PTR_ONE;
            if (do_pop)  rptr <= rptr + PTR_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !rst) mem[wptr[AW-1:0]] <= wdata;
    end

endmodule

// File: rtl/alu_driver.sv
// alu_driver: queues ALU commands, drives them one at a time onto an external
// combinational ALU, waits SETTLE cycles and returns result + flags through a
// valid/ready response channel.
//   clk, rst                 : clock, synchronous active-high reset
//   cmd_valid/cmd_ready      : command handshake; cmd_op, cmd_a, cmd_b payload
//   A, B, control            : operands and opcode driven to the ALU
//   result, Verflow, Carry,
//   Negative, Zero           : ALU outputs
//   rsp_valid/rsp_ready      : response handshake; rsp_result, rsp_flags {V,C,N,Z}
//   ops_done                 : count of completed responses (wraps)
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | waiting for a queued command; pops it onto A/B/control
// ST_ISSUE | operands on the ALU; loads the settle counter
// ST_WAIT  | counting settle cycles; captures result/flags at zero
// ST_RESP  | response held until rsp_ready
module alu_driver
    import alu_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int SETTLE     = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [1:0]  cmd_op,
    input  logic [31:0] cmd_a,
    input  logic [31:0] cmd_b,
    output logic [31:0] A,
    output logic [31:0] B,
    output logic [1:0]  control,
    input  logic [31:0] result,
    input  logic        Verflow,
    input  logic        Carry,
    input  logic        Negative,
    input  logic        Zero,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_result,
    output logic [3:0]  rsp_flags,
    output logic [15:0] ops_done
);

    localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE - 1);

    state_t     state;
    logic [3:0] settle_cnt;
    logic       fifo_full;
    logic       fifo_empty;
    logic       push;
    logic       pop;
    cmd_t       wcmd;
    cmd_t       head;

    assign cmd_ready = !fifo_full;
    // Commands presented during reset are dropped.
    assign push      = cmd_valid && cmd_ready && !rst;
    assign pop       = (state == ST_IDLE) && !fifo_empty;
    assign wcmd      = '{op: cmd_op, a: cmd_a, b: cmd_b};

    cmd_fifo #(
        .WIDTH (CMD_W),
        .DEPTH (FIFO_DEPTH)
    ) u_cmd_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .wdata (wcmd),
        .full  (fifo_full),
        .pop   (pop),
        .rdata (head),
        .empty (fifo_empty)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            settle_cnt <= '0;
            A          <= '0;
            B          <= '0;
            control    <= '0;
            rsp_result <= '0;
            rsp_flags  <= '0;
            rsp_valid  <= 1'b0;
            ops_done   <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (!fifo_empty) begin
                        A       <= head.a;
                        B       <= head.b;
                        control <= head.op;
                        state   <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    settle_cnt <= SETTLE_LOAD;
                    state      <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (settle_cnt == 4'd0) begin
                        rsp_result        <= result;
                        rsp_flags[FLAG_V] <= Verflow;
                        rsp_flags[FLAG_C] <= Carry;
                        rsp_flags[FLAG_N] <= Negative;
                        rsp_flags[FLAG_Z] <= Zero;
                        rsp_valid         <= 1'b1;
                        state             <= ST_RESP;
                    end else begin
                        settle_cnt <= settle_cnt - 4'd1;
                    end
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        ops_done  <= ops_done + 16'd1;
                        state     <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_driver.sv
// tb_alu_driver: drives alu_driver against a behavioural ALU and checks every
// response against a queue of accepted commands evaluated by the ALU rules.
// Inputs change 2 time units after a rising edge; checks happen on falling edges.
module tb_alu_driver;
    import alu_pkg::*;

    localparam int DEPTH  = 4;
    localparam int SETTLE = 1;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [1:0]  cmd_op;
    logic [31:0] cmd_a;
    logic [31:0] cmd_b;
    logic [31:0] A;
    logic [31:0] B;
    logic [1:0]  control;
    logic [31:0] result;
    logic        Verflow;
    logic        Carry;
    logic        Negative;
    logic        Zero;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_result;
    logic [3:0]  rsp_flags;
    logic [15:0] ops_done;

    always #5 clk = ~clk;

    alu_driver #(.FIFO_DEPTH(DEPTH), .SETTLE(SETTLE)) dut (
        .clk        (clk),
        .rst        (rst),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_op     (cmd_op),
        .cmd_a      (cmd_a),
        .cmd_b      (cmd_b),
        .A          (A),
        .B          (B),
        .control    (control),
        .result     (result),
        .Verflow    (Verflow),
        .Carry      (Carry),
        .Negative   (Negative),
        .Zero       (Zero),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_result (rsp_result),
        .rsp_flags  (rsp_flags),
        .ops_done   (ops_done)
    );

    // Arithmetic definition of the ALU: returns {V,C,N,Z,result}.
    function automatic logic [35:0] alu_ref(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [32:0] s;
        logic [31:0] r;
        logic        v;
        logic        c;
        v = 1'b0;
        c = 1'b0;
        case (op)
            2'b00: begin
                s = {1'b0, a} + {1'b0, b};
                r = s[31:0];
                c = s[32];
                v = (a[31] == b[31]) && (r[31] != a[31]);
            end
            2'b01: begin
                r = a - b;
                c = (a >= b);
                v = (a[31] != b[31]) && (r[31] != a[31]);
            end
            2'b10:   r = a & b;
            default: r = a | b;
        endcase
        return {v, c, r[31], (r == 32'd0), r};
    endfunction

    // The ALU the driver is wired to.
    assign {Verflow, Carry, Negative, Zero, result} = alu_ref(control, A, B);

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
    } tcmd_t;

    tcmd_t       expq[$];
    logic [15:0] exp_cnt = 16'd0;
    logic        cnt_due = 1'b0;
    logic        hold    = 1'b0;
    logic [31:0] hold_r;
    logic [3:0]  hold_f;

    // Scoreboard: sees each handshake one falling edge before the edge that
    // completes it.
    always @(negedge clk) begin
        tcmd_t       c;
        logic [35:0] e;
        if (cnt_due) chk("ops_done", 64'(ops_done), 64'(exp_cnt));
        cnt_due = 1'b0;
        if (hold) begin
            chk("rsp_hold_valid", 64'(rsp_valid), 64'd1);
            chk("rsp_hold_result", 64'(rsp_result), 64'(hold_r));
            chk("rsp_hold_flags", 64'(rsp_flags), 64'(hold_f));
        end
        hold = 1'b0;
        if (rst) begin
            expq.delete();
            exp_cnt = 16'd0;
        end else begin
            if (cmd_valid && cmd_ready) expq.push_back('{cmd_op, cmd_a, cmd_b});
            if (rsp_valid && rsp_ready) begin
                if (expq.size() == 0) begin
                    chk("rsp_spurious", 64'(expq.size()), 64'd1);
                end else begin
                    c = expq.pop_front();
                    e = alu_ref(c.op, c.a, c.b);
                    chk("rsp_result", 64'(rsp_result), 64'(e[31:0]));
                    chk("rsp_flags", 64'(rsp_flags), 64'(e[35:32]));
                    chk("alu_a", 64'(A), 64'(c.a));
                    chk("alu_b", 64'(B), 64'(c.b));
                    chk("alu_control", 64'(control), 64'(c.op));
                    exp_cnt = exp_cnt + 16'd1;
                    cnt_due = 1'b1;
                end
            end
            if (rsp_valid && !rsp_ready) begin
                hold   = 1'b1;
                hold_r = rsp_result;
                hold_f = rsp_flags;
            end
        end
    end

    // All driver tasks start and end 2 units after a rising edge.
    task automatic do_reset();
        rst       = 1'b1;
        cmd_valid = 1'b0;
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;
    endtask

    task automatic send(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        int w;
        w         = 0;
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_a     = a;
        cmd_b     = b;
        @(negedge clk);
        while (!cmd_ready && w < 300) begin
            @(negedge clk);
            w++;
        end
        if (w >= 300) chk("send_timeout", 64'(w), 64'd0);
        @(posedge clk);
        #2 cmd_valid = 1'b0;
    endtask

    // Single command on an idle driver with rsp_ready high.
    task automatic run_one(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] exp_r, input logic [3:0] mask, input logic [3:0] exp_f,
                           input bit check_lat, input string tag);
        int lat;
        rsp_ready = 1'b1;
        send(op, a, b);
        lat = 1;   // the accepting edge counts as the first
        @(negedge clk);
        while (!rsp_valid && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        if (check_lat) chk({tag, "_latency"}, 64'(lat), 64'(3 + SETTLE));
        chk({tag, "_result"}, 64'(rsp_result), 64'(exp_r));
        chk({tag, "_flags"}, 64'(rsp_flags & mask), 64'(exp_f));
        @(posedge clk);
        #2;
    endtask

    task automatic drain(input string tag);
        int w;
        w         = 0;
        rsp_ready = 1'b1;
        while ((expq.size() != 0 || rsp_valid) && w < 3000) begin
            @(posedge clk);
            #2 w++;
        end
        chk({tag, "_drained"}, 64'(expq.size()), 64'd0);
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0:       return 32'h0000_0000;
            1:       return 32'h8000_0000;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'h7FFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    logic rnd_done;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int seen;
        int w;
        rst       = 1'b1;
        cmd_valid = 1'b0;
        cmd_op    = 2'b00;
        cmd_a     = 32'd0;
        cmd_b     = 32'd0;
        rsp_ready = 1'b0;
        @(posedge clk);
        #2 do_reset();

        @(negedge clk);
        chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("rst_cmd_ready", 64'(cmd_ready), 64'd1);
        chk("rst_ops_done", 64'(ops_done), 64'd0);
        chk("rst_a", 64'(A), 64'd0);
        chk("rst_b", 64'(B), 64'd0);
        chk("rst_control", 64'(control), 64'd0);
        chk("rst_rsp_result", 64'(rsp_result), 64'd0);
        chk("rst_rsp_flags", 64'(rsp_flags), 64'd0);
        @(posedge clk);
        #2;

        // Directed vectors; flags are {V,C,N,Z}.
        run_one(ALU_ADD, 32'h8000_0000, 32'h8000_0001, 32'h0000_0001, 4'b1111, 4'b1100, 1'b1, "add_ovf");
        run_one(ALU_SUB, 32'd40, 32'd40, 32'd0, 4'b1011, 4'b0001, 1'b1, "sub_zero");
        run_one(ALU_AND, 32'h5555_5555, 32'hAAAA_AAAA, 32'd0, 4'b0001, 4'b0001, 1'b1, "and_zero");
        run_one(ALU_OR, 32'h0E00_0001, 32'h0003_000F, 32'h0E03_000F, 4'b0001, 4'b0000, 1'b1, "or_nz");
        @(negedge clk);
        chk("ops_after_directed", 64'(ops_done), 64'd4);
        @(posedge clk);
        #2;

        // Random traffic with random back-pressure.
        rnd_done = 1'b0;
        fork
            begin
                for (int i = 0; i < 150; i++) begin
                    logic [31:0] ra;
                    ra = pick();
                    send(2'($urandom_range(0, 3)), ra, ($urandom_range(0, 7) == 0) ? ra : pick());
                    repeat ($urandom_range(0, 2)) begin
                        @(posedge clk);
                        #2;
                    end
                end
                rnd_done = 1'b1;
            end
            begin
                while (!rnd_done) begin
                    @(posedge clk);
                    #2 rsp_ready = ($urandom_range(0, 2) != 0);
                end
            end
        join
        drain("random");

        // Fill: one command parked in RESP plus a full FIFO behind it.
        do_reset();
        rsp_ready = 1'b0;
        send(ALU_ADD, 32'd1, 32'd2);
        send(ALU_SUB, 32'd10, 32'd3);
        send(ALU_AND, 32'hF0F0_1234, 32'h0FF0_FFFF);
        send(ALU_OR, 32'h1000_0000, 32'h0000_0001);
        send(ALU_SUB, 32'd3, 32'd10);
        @(negedge clk);
        chk("fill_cmd_ready", 64'(cmd_ready), 64'd0);
        chk("fill_rsp_valid", 64'(rsp_valid), 64'd1);
        repeat (6) @(posedge clk);
        #2;
        drain("fill");
        @(negedge clk);
        chk("fill_ops_done", 64'(ops_done), 64'd5);
        @(posedge clk);
        #2;

        // Reset while WAIT is active with three commands queued.
        rsp_ready = 1'b0;
        for (int i = 0; i < 5; i++) send(ALU_ADD, 32'(i + 100), 32'd7);
        rsp_ready = 1'b1;
        @(posedge clk);
        #2 rsp_ready = 1'b0;
        w = 0;
        while (dut.state != ST_WAIT && w < 50) begin
            @(posedge clk);
            #2 w++;
        end
        chk("reach_wait", 64'(w < 50), 64'd1);
        rst       = 1'b1;
        cmd_valid = 1'b1;
        cmd_op    = ALU_OR;
        cmd_a     = 32'h1234_5678;
        cmd_b     = 32'h1;
        @(posedge clk);
        #2;
        rst       = 1'b0;
        cmd_valid = 1'b0;
        chk("midrst_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("midrst_cmd_ready", 64'(cmd_ready), 64'd1);
        chk("midrst_ops_done", 64'(ops_done), 64'd0);
        chk("midrst_rsp_result", 64'(rsp_result), 64'd0);
        chk("midrst_a", 64'(A), 64'd0);
        rsp_ready = 1'b1;
        seen      = 0;
        repeat (30) begin
            @(negedge clk);
            seen += int'(rsp_valid);
        end
        chk("midrst_no_stale", 64'(seen), 64'd0);
        @(posedge clk);
        #2;

        // ops_done wrap from 0xFFFF.
        force dut.ops_done = 16'hFFFF;
        exp_cnt = 16'hFFFF;
        #1 release dut.ops_done;
        @(posedge clk);
        #2;
        run_one(ALU_ADD, 32'd5, 32'd6, 32'd11, 4'b1111, 4'b0000, 1'b0, "wrap");
        chk("wrap_ops_done", 64'(ops_done), 64'd0);

        repeat (3) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
